sprite_compositor: RTL
======================

Name: sprite_compositor

Overview:
- Pipelined, parametrised successor to the combinational pixel generator.
- Composites a background pixel (map_rgb) with up to OBJ_NUM rectangular objects into a registered rgb output.
- The object table is written through a valid/ready port into a shadow table. The shadow is committed to the active table only at frame start, so no frame ever shows a torn update.
- Sits between the VGA controller and the VGA port.

Parameters:
- OBJ_NUM, 16, number of object slots (2..32)
- IDX_WIDTH, 4, index width, ceil(log2(OBJ_NUM))
- PHY_WIDTH, 16, absolute coordinate width
- SCREEN_WIDTH, 10, screen x/y width
- CAM_WIDTH, 5, camera_y width
- BLOCK_WIDTH, 480, world rows per camera step
- SIZE_WIDTH, 9, object width/height field width
- PIXEL_WIDTH, 12, colour width
- TRANSPARENT, 12'hF0F, colour key treated as "no hit"
- BORDER_RGB, 12'hFFF, colour used when map_on=0

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- pix_tick  in  1  pixel enable; the pipeline advances only when high
- video_on  in  1  from VGA controller
- frame_start  in  1  pulse, qualified by pix_tick, on pixel (0,0)
- x  in  SCREEN_WIDTH  current pixel x
- y  in  SCREEN_WIDTH  current pixel y
- camera_y  in  CAM_WIDTH  camera step
- map_rgb  in  PIXEL_WIDTH  background colour aligned with x/y
- map_on  in  1  background valid for x/y
- obj_wr_valid  in  1  table write request
- obj_wr_ready  out  1  table write accept
- obj_wr_idx  in  IDX_WIDTH  slot number
- obj_wr_en  in  1  slot enable
- obj_wr_x  in  PHY_WIDTH  absolute x
- obj_wr_y  in  PHY_WIDTH  absolute y
- obj_wr_w  in  SIZE_WIDTH  width in pixels
- obj_wr_h  in  SIZE_WIDTH  height in pixels
- obj_wr_color  in  PIXEL_WIDTH  fill colour
- rgb  out  PIXEL_WIDTH  composited pixel
- rgb_valid  out  1  delayed video_on
- hit_idx  out  IDX_WIDTH  winning slot, 0 if none
- hit_any  out  1  an object won this pixel
- commit_pending  out  1  shadow differs from active

Behaviour:
- Reset: rgb=0, rgb_valid=0, hit_idx=0, hit_any=0, commit_pending=0, obj_wr_ready=1.
- Reset also clears all shadow and active slots, including the enable bits, and all pipeline registers.
- Pipeline advances only on pix_tick. Outputs hold between ticks. Latency is exactly 3 pix_ticks from x/y/video_on to rgb/rgb_valid.
- Stage 1 registers:
  - wy = y + camera_y*BLOCK_WIDTH, computed in PHY_WIDTH+1 bits
  - x zero-extended
  - video_on, map_rgb, map_on
- Stage 2 registers the hit vector. Slot k hits when all of the following hold:
  - the active slot is enabled
  - colour != TRANSPARENT
  - x >= ox and x < ox+w
  - wy >= oy and wy < oy+h
  - all compares are unsigned in PHY_WIDTH+1 bits, so ox+w and oy+h never wrap
  - w=0 or h=0 never hits
- Stage 3 output:
  - If video_on is low: rgb=0.
  - Else if any slot hits: the lowest-index hit wins; rgb = its colour, hit_any=1, hit_idx=k.
  - Else if map_on: rgb = map_rgb.
  - Else: rgb = BORDER_RGB.
  - hit_any=0 and hit_idx=0 whenever no object wins.
- Write port:
  - A transfer occurs on a cycle with obj_wr_valid & obj_wr_ready. It writes the shadow slot obj_wr_idx and sets commit_pending=1.
  - obj_wr_idx >= OBJ_NUM: the write is accepted and dropped, and commit_pending is unchanged.
- Commit:
  - Occurs on a cycle with pix_tick & frame_start & commit_pending. The whole shadow copies to active and commit_pending clears.
  - obj_wr_ready=0 during that commit cycle only (combinational), so a concurrent write is held off and lands in the next frame.
  - The pixel sampled on the frame_start tick and every later pixel of that frame use the new table. Pixels already in stages 2/3 use the old one.
- Writes to the same slot before a commit: the last write wins.
- frame_start without commit_pending: no effect.
- Reset mid-frame: outputs return to reset values immediately. The first valid rgb appears 3 ticks after the first tick following reset release.

Decomposition:
- Package pixel_pkg holds:
  - colour constants (RED…MAROON, TRANSPARENT)
  - the obj_entry_t struct {en, x, y, w, h, color}
  - PIPE_LATENCY=3
- One sub-module, obj_hit_test: a combinational per-slot compare taking obj_entry_t, x, and wy, and returning hit. It is instantiated OBJ_NUM times in a generate loop.
- Priority encoder and table registers stay in the top module.

Test Plan:
- Reset and latency:
  - Stimulus: reset, then 4 ticks with map_on=1, map_rgb=12'h2A6, video_on=1.
  - Required: rgb=0 and rgb_valid=0 during reset; rgb=12'h2A6 and rgb_valid=1 exactly on the 3rd tick.
- Priority:
  - Stimulus: slot 2 = (x 100, y 50, 32×32, 12'h00F) and slot 5 = (x 110, y 60, 32×32, 12'hF80); commit; pixel (115,65), camera_y=0.
  - Required: rgb=12'h00F, hit_idx=2.
  - Stimulus: pixel (140,90).
  - Required: rgb=12'hF80, hit_idx=5.
- Camera scroll:
  - Stimulus: slot 0 at y=530, h=20; camera_y=1.
  - Required: screen y=50..69 hits, y=49 and y=70 do not.
- Frame-atomic commit:
  - Stimulus: write slot 1 colour 12'hFFF mid-frame.
  - Required: rgb unchanged until frame_start, commit_pending=1, then the new colour from pixel (0,0) onward.
  - Stimulus: a write presented on the commit tick.
  - Required: ready=0 that cycle, accepted the next cycle, commit_pending=1 again.
- Boundaries:
  - Stimulus: ox=0xFFF0, w=32.
  - Required: no wrap hit at x=0.
  - Stimulus: a w=0 slot; obj_wr_idx=OBJ_NUM; colour=TRANSPARENT.
  - Required: none of them ever hits; the out-of-range index leaves commit_pending unchanged.
- Video blanking:
  - Stimulus: video_on=0 with an object over the pixel.
  - Required: 3 ticks later rgb=0, rgb_valid=0, hit_any=0.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared definitions for the sprite compositor: palette, object-table entry
// layout and pipeline depth.
package pixel_pkg;

    localparam int OBJ_PHY_W    = 16;
    localparam int OBJ_SIZE_W   = 9;
    localparam int OBJ_PIX_W    = 12;
    localparam int PIPE_LATENCY = 3;

    localparam logic [OBJ_PIX_W-1:0] BLACK       = 12'h000;
    localparam logic [OBJ_PIX_W-1:0] WHITE       = 12'hFFF;
    localparam logic [OBJ_PIX_W-1:0] RED         = 12'hF00;
    localparam logic [OBJ_PIX_W-1:0] GREEN       = 12'h0F0;
    localparam logic [OBJ_PIX_W-1:0] BLUE        = 12'h00F;
    localparam logic [OBJ_PIX_W-1:0] YELLOW      = 12'hFF0;
    localparam logic [OBJ_PIX_W-1:0] CYAN        = 12'h0FF;
    localparam logic [OBJ_PIX_W-1:0] MAROON      = 12'h800;
    localparam logic [OBJ_PIX_W-1:0] TRANSPARENT = 12'hF0F;

    typedef struct packed {
        logic                  en;
        logic [OBJ_PHY_W-1:0]  x;
        logic [OBJ_PHY_W-1:0]  y;
        logic [OBJ_SIZE_W-1:0] w;
        logic [OBJ_SIZE_W-1:0] h;
        logic [OBJ_PIX_W-1:0]  color;
    } obj_entry_t;

endpackage

// File: rtl/obj_hit_test.sv
// Combinational rectangle test for one object slot against a world-space pixel.
module obj_hit_test #(
    parameter logic [pixel_pkg::OBJ_PIX_W-1:0] KEY_RGB = pixel_pkg::TRANSPARENT
) (
    input  pixel_pkg::obj_entry_t          obj_i,
    input  logic [pixel_pkg::OBJ_PHY_W:0]  x_i,
    input  logic [pixel_pkg::OBJ_PHY_W:0]  wy_i,
    output logic                           hit_o
);
    import pixel_pkg::*;

    localparam int AW = OBJ_PHY_W + 1;

    logic [AW-1:0] x_lo, x_hi, y_lo, y_hi;

    // One extra bit keeps the far edges from wrapping past the coordinate space.
    assign x_lo = AW'(obj_i.x);
    assign x_hi = x_lo + AW'(obj_i.w);
    assign y_lo = AW'(obj_i.y);
    assign y_hi = y_lo + AW'(obj_i.h);

    assign hit_o = obj_i.en && (obj_i.color != KEY_RGB)
                   && (x_i >= x_lo) && (x_i < x_hi)
                   && (wy_i >= y_lo) && (wy_i < y_hi);

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage pixel compositor: background plus prioritised rectangular objects,
// with a shadow object table committed atomically at frame start.
module sprite_compositor #(
    parameter int OBJ_NUM      = 16,
    parameter int IDX_WIDTH    = 4,
    parameter int PHY_WIDTH    = 16,
    parameter int SCREEN_WIDTH = 10,
    parameter int CAM_WIDTH    = 5,
    parameter int BLOCK_WIDTH  = 480,
    parameter int SIZE_WIDTH   = 9,
    parameter int PIXEL_WIDTH  = 12,
    parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT = 12'hF0F,
    parameter logic [PIXEL_WIDTH-1:0] BORDER_RGB  = 12'hFFF
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    pix_tick,
    input  logic                    video_on,
    input  logic                    frame_start,
    input  logic [SCREEN_WIDTH-1:0] x,
    input  logic [SCREEN_WIDTH-1:0] y,
    input  logic [CAM_WIDTH-1:0]    camera_y,
    input  logic [PIXEL_WIDTH-1:0]  map_rgb,
    input  logic                    map_on,
    input  logic                    obj_wr_valid,
    output logic                    obj_wr_ready,
    input  logic [IDX_WIDTH-1:0]    obj_wr_idx,
    input  logic                    obj_wr_en,
    input  logic [PHY_WIDTH-1:0]    obj_wr_x,
    input  logic [PHY_WIDTH-1:0]    obj_wr_y,
    input  logic [SIZE_WIDTH-1:0]   obj_wr_w,
    input  logic [SIZE_WIDTH-1:0]   obj_wr_h,
    input  logic [PIXEL_WIDTH-1:0]  obj_wr_color,
    output logic [PIXEL_WIDTH-1:0]  rgb,
    output logic                    rgb_valid,
    output logic [IDX_WIDTH-1:0]    hit_idx,
    output logic                    hit_any,
    output logic                    commit_pending
);
    import pixel_pkg::*;

    localparam int AW = PHY_WIDTH + 1;
    localparam logic [IDX_WIDTH:0] SLOT_LIMIT = OBJ_NUM[IDX_WIDTH:0];

    obj_entry_t shadow_q [OBJ_NUM];
    obj_entry_t active_q [OBJ_NUM];
    obj_entry_t wr_entry;
    logic       commit_pending_q;
    logic       commit, wr_fire, wr_in_range;

    assign commit       = pix_tick & frame_start & commit_pending_q;
    assign obj_wr_ready = ~commit;
    assign wr_fire      = obj_wr_valid & obj_wr_ready;
    assign wr_in_range  = {1'b0, obj_wr_idx} < SLOT_LIMIT;
    assign wr_entry     = '{en: obj_wr_en, x: obj_wr_x, y: obj_wr_y,
                            w: obj_wr_w, h: obj_wr_h, color: obj_wr_color};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < OBJ_NUM; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            commit_pending_q <= 1'b0;
        end else if (commit) begin
            for (int k = 0; k < OBJ_NUM; k++) begin
                active_q[k] <= shadow_q[k];
            end
            commit_pending_q <= 1'b0;
        end else if (wr_fire && wr_in_range) begin
            shadow_q[obj_wr_idx] <= wr_entry;
            commit_pending_q     <= 1'b1;
        end
    end

    logic [AW-1:0]          wy_d, s1_x_q, s1_wy_q;
    logic                   s1_video_q, s1_map_on_q;
    logic [PIXEL_WIDTH-1:0] s1_map_rgb_q;

    assign wy_d = AW'(y) + AW'(camera_y) * AW'(BLOCK_WIDTH);

    logic [OBJ_NUM-1:0]     hit_d, s2_hit_q;
    logic [PIXEL_WIDTH-1:0] win_color_d, s2_color_q, s2_map_rgb_q;
    logic                   s2_video_q, s2_map_on_q;

    for (genvar g = 0; g < OBJ_NUM; g++) begin : g_hit
        obj_hit_test #(.KEY_RGB(TRANSPARENT)) u_hit (
            .obj_i (active_q[g]),
            .x_i   (s1_x_q),
            .wy_i  (s1_wy_q),
            .hit_o (hit_d[g])
        );
    end

    // Winner colour is captured alongside the hit vector so a commit landing
    // while this pixel sits in stage 3 cannot recolour it.
    always_comb begin
        win_color_d = '0;
        for (int k = OBJ_NUM - 1; k >= 0; k--) begin
            if (hit_d[k]) win_color_d = active_q[k].color;
        end
    end

    logic [IDX_WIDTH-1:0]   win_idx, hit_idx_d, hit_idx_q;
    logic [PIXEL_WIDTH-1:0] rgb_d, rgb_q;
    logic                   hit_any_d, hit_any_q, rgb_valid_q;

    always_comb begin
        win_idx = '0;
        for (int k = OBJ_NUM - 1; k >= 0; k--) begin
            if (s2_hit_q[k]) win_idx = IDX_WIDTH'(k);
        end
        rgb_d     = '0;
        hit_any_d = 1'b0;
        hit_idx_d = '0;
        if (s2_video_q) begin
            if (|s2_hit_q) begin
                rgb_d     = s2_color_q;
                hit_any_d = 1'b1;
                hit_idx_d = win_idx;
            end else if (s2_map_on_q) begin
                rgb_d = s2_map_rgb_q;
            end else begin
                rgb_d = BORDER_RGB;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_x_q       <= '0;
            s1_wy_q      <= '0;
            s1_video_q   <= 1'b0;
            s1_map_on_q  <= 1'b0;
            s1_map_rgb_q <= '0;
            s2_hit_q     <= '0;
            s2_color_q   <= '0;
            s2_video_q   <= 1'b0;
            s2_map_on_q  <= 1'b0;
            s2_map_rgb_q <= '0;
            rgb_q        <= '0;
            rgb_valid_q  <= 1'b0;
            hit_any_q    <= 1'b0;
            hit_idx_q    <= '0;
        end else if (pix_tick) begin
            s1_x_q       <= AW'(x);
            s1_wy_q      <= wy_d;
            s1_video_q   <= video_on;
            s1_map_on_q  <= map_on;
            s1_map_rgb_q <= map_rgb;
            s2_hit_q     <= hit_d;
            s2_color_q   <= win_color_d;
            s2_video_q   <= s1_video_q;
            s2_map_on_q  <= s1_map_on_q;
            s2_map_rgb_q <= s1_map_rgb_q;
            rgb_q        <= rgb_d;
            rgb_valid_q  <= s2_video_q;
            hit_any_q    <= hit_any_d;
            hit_idx_q    <= hit_idx_d;
        end
    end

    assign rgb            = rgb_q;
    assign rgb_valid      = rgb_valid_q;
    assign hit_any        = hit_any_q;
    assign hit_idx        = hit_idx_q;
    assign commit_pending = commit_pending_q;

endmodule
